// File: rtl/trap_sequencer.sv
// M-mode trap-entry / MRET sequencer between the controller and csrUnit.
// Samples exceptions and the gated timer interrupt at retire, strobes csrUnit, then redirects fetch.
module trap_sequencer #(
    parameter int XLEN   = 32,
    parameter int CNT_W  = 16,
    parameter bit INT_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid_i,
    input  logic [XLEN-1:0]  pc_i,
    input  logic [31:0]      instr_i,
    input  logic [XLEN-1:0]  exc_addr_i,
    input  logic             exc_if_mis_i,
    input  logic             exc_illegal_i,
    input  logic             exc_ecall_i,
    input  logic             exc_ebreak_i,
    input  logic             exc_st_mis_i,
    input  logic             exc_ld_mis_i,
    input  logic             mret_i,
    input  logic             mtime_exc_i,
    input  logic [XLEN-1:0]  mtvec_i,
    input  logic [XLEN-1:0]  mepc_i,
    output logic             stall_o,
    output logic             flush_o,
    output logic             jumpingToMtvec_o,
    output logic [31:0]      excCause_o,
    output logic [31:0]      trapInfo_o,
    output logic [XLEN-1:0]  trap_pc_o,
    output logic             mret_o,
    output logic             redirect_o,
    output logic [XLEN-1:0]  redirect_pc_o,
    output logic [CNT_W-1:0] trap_count_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRAP  = 2'd1,
        REDIR = 2'd2,
        MRET  = 2'd3
    } state_t;

    localparam logic [31:0] CAUSE_TIMER  = 32'h8000_0007;
    localparam logic [31:0] CAUSE_IF_MIS = 32'd0;
    localparam logic [31:0] CAUSE_ILL    = 32'd2;
    localparam logic [31:0] CAUSE_EBRK   = 32'd3;
    localparam logic [31:0] CAUSE_LD_MIS = 32'd4;
    localparam logic [31:0] CAUSE_ST_MIS = 32'd6;
    localparam logic [31:0] CAUSE_ECALL  = 32'd11;
    // Redirect targets are always word aligned: the low two bits of mtvec hold the MODE field.
    localparam logic [XLEN-1:0] PC_MASK  = {{(XLEN-2){1'b1}}, 2'b00};

    state_t           state_q, state_d;
    logic [31:0]      cause_q, cause_d;
    logic [31:0]      tval_q, tval_d;
    logic [XLEN-1:0]  epc_q, epc_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic        timer_irq;
    logic        any_exc;
    logic        trap_take;
    logic        mret_take;
    logic [31:0] sel_cause;
    logic [31:0] sel_tval;

    assign timer_irq = INT_EN & mtime_exc_i;
    assign any_exc   = exc_if_mis_i | exc_illegal_i | exc_ecall_i |
                       exc_ebreak_i | exc_st_mis_i  | exc_ld_mis_i;
    assign trap_take = instr_valid_i & (any_exc | timer_irq);
    assign mret_take = instr_valid_i & mret_i & ~trap_take;

    // Fixed priority: interrupt first, then synchronous exceptions in architectural order.
    always_comb begin
        sel_cause = '0;
        sel_tval  = '0;
        if (timer_irq) begin
            sel_cause = CAUSE_TIMER;
        end else if (exc_if_mis_i) begin
            sel_cause = CAUSE_IF_MIS;
            sel_tval  = 32'(exc_addr_i);
        end else if (exc_illegal_i) begin
            sel_cause = CAUSE_ILL;
            sel_tval  = instr_i;
        end else if (exc_ecall_i) begin
            sel_cause = CAUSE_ECALL;
        end else if (exc_ebreak_i) begin
            sel_cause = CAUSE_EBRK;
        end else if (exc_st_mis_i) begin
            sel_cause = CAUSE_ST_MIS;
            sel_tval  = 32'(exc_addr_i);
        end else if (exc_ld_mis_i) begin
            sel_cause = CAUSE_LD_MIS;
            sel_tval  = 32'(exc_addr_i);
        end
    end

    always_comb begin
        state_d          = state_q;
        cause_d          = cause_q;
        tval_d           = tval_q;
        epc_d            = epc_q;
        count_d          = count_q;
        stall_o          = 1'b0;
        flush_o          = 1'b0;
        jumpingToMtvec_o = 1'b0;
        excCause_o       = '0;
        trapInfo_o       = '0;
        trap_pc_o        = '0;
        mret_o           = 1'b0;
        redirect_o       = 1'b0;
        redirect_pc_o    = '0;

        case (state_q)
            IDLE: begin
                if (trap_take) begin
                    state_d = TRAP;
                    cause_d = sel_cause;
                    tval_d  = sel_tval;
                    epc_d   = pc_i;
                    // Keep outputs quiet while reset is held, even if the retire stage shows a trap.
                    flush_o = ~rst;
                    if (count_q != {CNT_W{1'b1}}) begin
                        count_d = count_q + 1'b1;
                    end
                end else if (mret_take) begin
                    state_d = MRET;
                end
            end
            TRAP: begin
                state_d          = REDIR;
                stall_o          = 1'b1;
                jumpingToMtvec_o = 1'b1;
                excCause_o       = cause_q;
                trapInfo_o       = tval_q;
                trap_pc_o        = epc_q;
            end
            REDIR: begin
                // mtvec is sampled here, one cycle after csrUnit committed the trap.
                state_d       = IDLE;
                stall_o       = 1'b1;
                redirect_o    = 1'b1;
                redirect_pc_o = mtvec_i & PC_MASK;
            end
            MRET: begin
                state_d       = IDLE;
                stall_o       = 1'b1;
                mret_o        = 1'b1;
                redirect_o    = 1'b1;
                redirect_pc_o = mepc_i & PC_MASK;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cause_q <= '0;
            tval_q  <= '0;
            epc_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            tval_q  <= tval_d;
            epc_q   <= epc_d;
            count_q <= count_d;
        end
    end

    assign trap_count_o = count_q;

endmodule
